// File: rtl/trigger_network_scheduler.sv
// Central scheduler for a network of trigger actors: launches enabled actors,
// broadcasts registered sleep/sync aggregates, detects quiescence and keeps stats.
module trigger_network_scheduler #(
  parameter int unsigned NUM_ACTORS = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  input  logic [NUM_ACTORS-1:0] actor_mask,
  output logic [NUM_ACTORS-1:0] trigger_start,
  input  logic [NUM_ACTORS-1:0] trigger_idle,
  input  logic [NUM_ACTORS-1:0] trigger_sleep,
  input  logic [NUM_ACTORS-1:0] trigger_sync_exec,
  input  logic [NUM_ACTORS-1:0] trigger_sync_wait,
  output logic                  all_sleep,
  output logic                  all_sync,
  output logic                  all_sync_wait,
  output logic [CNT_WIDTH-1:0]  sync_rounds,
  output logic [CNT_WIDTH-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_ACTORS-1:0] mask_q;
  logic                  c_sleep;
  logic                  c_sync;
  logic                  c_wait;
  logic                  c_idle;
  logic                  in_run;
  logic                  in_count;

  // Masked-off actors satisfy every aggregate condition.
  assign c_sleep  = &(trigger_sleep | ~mask_q);
  assign c_sync   = &((trigger_sync_exec | trigger_sync_wait) | ~mask_q);
  assign c_wait   = &(trigger_sync_wait | ~mask_q);
  assign c_idle   = &(trigger_idle | ~mask_q);
  assign in_run   = (state_q == S_RUN);
  assign in_count = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = (actor_mask == '0) ? S_DONE : S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (all_sync_wait) state_d = S_DRAIN;
      S_DRAIN: if (c_idle) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the FSM.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      ap_done       <= 1'b0;
      ap_ready      <= 1'b0;
      ap_idle       <= 1'b1;
      trigger_start <= '0;
      all_sleep     <= 1'b0;
      all_sync      <= 1'b0;
      all_sync_wait <= 1'b0;
      sync_rounds   <= '0;
      run_cycles    <= '0;
    end else begin
      state_q       <= state_d;
      ap_idle       <= (state_d == S_IDLE);
      ap_done       <= (state_d == S_DONE);
      ap_ready      <= (state_d == S_DONE);
      trigger_start <= (state_d == S_START) ? actor_mask : '0;
      // "& ~self" turns each aggregate into a single-cycle pulse.
      all_sleep     <= in_run & c_sleep & ~all_sleep;
      all_sync      <= in_run & c_sync & ~all_sync;
      all_sync_wait <= in_run & c_sync & c_wait & ~all_sync;
      if ((state_q == S_IDLE) && ap_start) begin
        mask_q      <= actor_mask;
        sync_rounds <= '0;
        run_cycles  <= '0;
      end else begin
        if (in_count && (run_cycles != '1))
          run_cycles <= run_cycles + CNT_WIDTH'(1);
        if (in_run && all_sync && !all_sync_wait && (sync_rounds != '1))
          sync_rounds <= sync_rounds + CNT_WIDTH'(1);
      end
    end
  end

endmodule
